// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D-cache to slow-memory arbiter.
// FSM state encoding, grant encoding and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_I  = 3'd1,
        BUSY_D  = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the arbiter.
// slave = arbiter view, master = caches plus slow memory.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              proto_err;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output proto_err
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  proto_err
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant picker: round-robin, or fixed D-first.
// last grant starts at I so the first tie goes to D.
module rr_arb2
    import mem_arbiter_pkg::*;
#(
    parameter int D_PRIORITY = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   update,
    output logic   valid,
    output grant_t grant
);

    grant_t last_q;

    // pick the winner from the live requests and the last grant
    always_comb begin
        valid = req_i | req_d;
        grant = GRANT_I;
        if (req_i && req_d) begin
            if (D_PRIORITY != 0 || last_q == GRANT_I) grant = GRANT_D;
            else                                      grant = GRANT_I;
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

    // remember who was served last, only when a grant is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 last_q <= GRANT_I;
        else if (update && valid) last_q <= grant;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow-memory port between I-cache and D-cache.
// One outstanding access; registered grant, DONE pulse, RELEASE gap.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int D_PRIORITY = 0
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    state_t state_q, state_d;
    grant_t owner_q, grant;

    logic grant_valid, take, finish;
    logic req_i, req_d, sel_write;
    logic both_i, both_d;

    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_ready_q, d_ready_q;
    logic              perr_q;

    assign req_i  = bus.i_read | bus.i_write;
    assign req_d  = bus.d_read | bus.d_write;
    assign both_i = bus.i_read & bus.i_write;
    assign both_d = bus.d_read & bus.d_write;

    // write wins when a client raises both ops at once
    assign sel_write = (grant == GRANT_D) ? bus.d_write : bus.i_write;

    rr_arb2 #(.D_PRIORITY(D_PRIORITY)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .req_d  (req_d),
        .update (take),
        .valid  (grant_valid),
        .grant  (grant)
    );

    // next state plus the grant/complete strobes
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    take    = 1'b1;
                    state_d = (grant == GRANT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // latch the granted request, return data and ready pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= GRANT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            if (state_q == IDLE && (both_i || both_d)) perr_q <= 1'b1;
            if (take) begin
                owner_q     <= grant;
                addr_q      <= (grant == GRANT_D) ? bus.d_addr : bus.i_addr;
                wdata_q     <= (grant == GRANT_D) ? bus.d_wdata : bus.i_wdata;
                mem_write_q <= sel_write;
                mem_read_q  <= ~sel_write;
            end
            if (finish) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (owner_q == GRANT_D) begin
                    d_ready_q <= 1'b1;
                    if (mem_read_q) d_rdata_q <= bus.mem_rdata;
                end else begin
                    i_ready_q <= 1'b1;
                    if (mem_read_q) i_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and D-first instances.
// Transaction-level model of grants, memory contents and readback.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;

    logic          i_read = 1'b0, i_write = 1'b0;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_dp ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1)) dut_dp (
        .clk (clk),
        .rst (rst),
        .bus (bus_dp)
    );

    always #5 clk = ~clk;

    assign bus_rr.i_read    = i_read & ~sel;
    assign bus_rr.i_write   = i_write & ~sel;
    assign bus_rr.d_read    = d_read & ~sel;
    assign bus_rr.d_write   = d_write & ~sel;
    assign bus_rr.i_addr    = i_addr;
    assign bus_rr.d_addr    = d_addr;
    assign bus_rr.i_wdata   = i_wdata;
    assign bus_rr.d_wdata   = d_wdata;
    assign bus_rr.mem_rdata = mem_rdata;
    assign bus_rr.mem_ready = mem_ready & ~sel;

    assign bus_dp.i_read    = i_read & sel;
    assign bus_dp.i_write   = i_write & sel;
    assign bus_dp.d_read    = d_read & sel;
    assign bus_dp.d_write   = d_write & sel;
    assign bus_dp.i_addr    = i_addr;
    assign bus_dp.d_addr    = d_addr;
    assign bus_dp.i_wdata   = i_wdata;
    assign bus_dp.d_wdata   = d_wdata;
    assign bus_dp.mem_rdata = mem_rdata;
    assign bus_dp.mem_ready = mem_ready & sel;

    logic          o_mem_read, o_mem_write, o_i_ready, o_d_ready, o_perr;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_i_rdata, o_d_rdata;

    assign o_mem_read  = sel ? bus_dp.mem_read  : bus_rr.mem_read;
    assign o_mem_write = sel ? bus_dp.mem_write : bus_rr.mem_write;
    assign o_mem_addr  = sel ? bus_dp.mem_addr  : bus_rr.mem_addr;
    assign o_mem_wdata = sel ? bus_dp.mem_wdata : bus_rr.mem_wdata;
    assign o_i_ready   = sel ? bus_dp.i_ready   : bus_rr.i_ready;
    assign o_d_ready   = sel ? bus_dp.d_ready   : bus_rr.d_ready;
    assign o_i_rdata   = sel ? bus_dp.i_rdata   : bus_rr.i_rdata;
    assign o_d_rdata   = sel ? bus_dp.d_rdata   : bus_rr.d_rdata;
    assign o_perr      = sel ? bus_dp.proto_err : bus_rr.proto_err;

    // reference model state, one slot per instance (0 = rr, 1 = D-first)
    bit            pend_i = 1'b0, pend_d = 1'b0;
    bit            last_g [2];
    logic [DW-1:0] exp_rd_i [2];
    logic [DW-1:0] exp_rd_d [2];
    bit            exp_perr [2];
    logic [DW-1:0] mem_model [logic [AW-1:0]];

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {4{4'h5, a}};
    endfunction

    function automatic logic [DW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k]   = 1'b0;
            exp_rd_i[k] = '0;
            exp_rd_d[k] = '0;
            exp_perr[k] = 1'b0;
        end
    endtask

    task automatic clear_reqs();
        i_read = 1'b0; i_write = 1'b0; pend_i = 1'b0;
        d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0;
    endtask

    task automatic new_req(bit side);
        bit w;
        logic [AW-1:0] a;
        w = 1'($urandom_range(0, 1));
        a = AW'($urandom_range(0, 15));
        if (side) begin
            d_read = !w; d_write = w; d_addr = a;
            d_wdata = rnd_line(); pend_d = 1'b1;
        end else begin
            i_read = !w; i_write = w; i_addr = a;
            i_wdata = rnd_line(); pend_i = 1'b1;
        end
    endtask

    // one full arbitration: called on a negedge where the DUT is IDLE
    task automatic do_txn(bit keep, output bit won_d);
        bit            win_d, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        int            lat;
        if ((i_read && i_write) || (d_read && d_write)) exp_perr[sel] = 1'b1;
        if (pend_i && pend_d) win_d = (sel == 1'b1) || (last_g[sel] == 1'b0);
        else                  win_d = pend_d;
        last_g[sel] = win_d;
        won_d = win_d;
        wr = win_d ? d_write : i_write;
        a  = win_d ? d_addr : i_addr;
        wd = win_d ? d_wdata : i_wdata;
        @(negedge clk);
        chk("grant_read", o_mem_read, !wr);
        chk("grant_write", o_mem_write, wr);
        chk("grant_addr", o_mem_addr, a);
        chk("grant_wdata", o_mem_wdata, wd);
        chk("busy_no_ready", o_i_ready | o_d_ready, 1'b0);
        if (!keep) begin
            if (win_d) d_addr = ~a;
            else       i_addr = ~a;
        end
        lat = $urandom_range(0, 2);
        repeat (lat) begin
            @(negedge clk);
            chk("hold_addr", o_mem_addr, a);
            chk("hold_op", {o_mem_read, o_mem_write}, {!wr, wr});
            chk("hold_no_ready", o_i_ready | o_d_ready, 1'b0);
        end
        if (wr) begin
            rd = rnd_line();
            mem_model[a] = wd;
        end else begin
            rd = model_read(a);
        end
        mem_rdata = rd;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = rnd_line();
        if (!wr) begin
            if (win_d) exp_rd_d[sel] = rd;
            else       exp_rd_i[sel] = rd;
        end
        chk("i_ready", o_i_ready, !win_d);
        chk("d_ready", o_d_ready, win_d);
        chk("done_mem_idle", {o_mem_read, o_mem_write}, 2'b00);
        chk("i_rdata", o_i_rdata, exp_rd_i[sel]);
        chk("d_rdata", o_d_rdata, exp_rd_d[sel]);
        chk("proto_err", o_perr, exp_perr[sel]);
        if (!keep) begin
            if (win_d) begin d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0; end
            else       begin i_read = 1'b0; i_write = 1'b0; pend_i = 1'b0; end
        end
        @(negedge clk);
        chk("release_no_ready", o_i_ready | o_d_ready, 1'b0);
        chk("release_mem_idle", {o_mem_read, o_mem_write}, 2'b00);
        @(negedge clk);
    endtask

    // async reset raised mid-cycle; outputs must drop before the next edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_read", o_mem_read, 1'b0);
        chk("rst_mem_write", o_mem_write, 1'b0);
        chk("rst_i_ready", o_i_ready, 1'b0);
        chk("rst_d_ready", o_d_ready, 1'b0);
        chk("rst_perr", o_perr, 1'b0);
        chk("rst_state", dut_rr.state_q, IDLE);
        clear_reqs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit won;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_mem_read", o_mem_read, 1'b0);
        chk("init_mem_write", o_mem_write, 1'b0);
        chk("init_mem_addr", o_mem_addr, '0);
        chk("init_mem_wdata", o_mem_wdata, '0);
        chk("init_i_rdata", o_i_rdata, '0);
        chk("init_d_rdata", o_d_rdata, '0);
        chk("init_readys", {o_i_ready, o_d_ready}, 2'b00);
        chk("init_perr", o_perr, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // single I read
        mem_model[28'h0000010] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        i_read = 1'b1; i_addr = 28'h0000010; pend_i = 1'b1;
        do_txn(1'b0, won);
        chk("single_i_grant", won, 1'b0);
        chk("single_i_rdata", o_i_rdata, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

        // I read and D write together after reset: D then I
        do_reset();
        @(negedge clk);
        i_read = 1'b1; i_addr = 28'h0000010; pend_i = 1'b1;
        d_write = 1'b1; d_addr = 28'h0000020; pend_d = 1'b1;
        d_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        do_txn(1'b0, won);
        chk("tie_first_d", won, 1'b1);
        do_txn(1'b0, won);
        chk("tie_then_i", won, 1'b0);

        // spurious mem_ready in IDLE
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("spur_no_ready", {o_i_ready, o_d_ready}, 2'b00);
        chk("spur_mem_idle", {o_mem_read, o_mem_write}, 2'b00);
        @(negedge clk);
        chk("spur_no_ready2", {o_i_ready, o_d_ready}, 2'b00);
        new_req(1'b1);
        do_txn(1'b0, won);

        // randomized traffic, round-robin instance
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) new_req(1'b0);
            if (!pend_d && $urandom_range(0, 1) == 1) new_req(1'b1);
            if (!pend_i && !pend_d) new_req(1'($urandom_range(0, 1)));
            do_txn($urandom_range(0, 3) == 0, won);
        end

        // fairness with both holding requests
        do_reset();
        @(negedge clk);
        new_req(1'b0);
        new_req(1'b1);
        for (int k = 0; k < 6; k++) begin
            do_txn(1'b1, won);
            chk("rr_alternate", won, (k % 2) == 0);
        end
        clear_reqs();

        // read and write together: write wins, error is sticky
        d_read = 1'b1; d_write = 1'b1; pend_d = 1'b1;
        d_addr = 28'h0000030; d_wdata = rnd_line();
        do_txn(1'b0, won);
        chk("perr_set", o_perr, 1'b1);
        new_req(1'b0);
        do_txn(1'b0, won);
        chk("perr_sticky", o_perr, 1'b1);

        // reset while BUSY_I
        i_read = 1'b1; i_write = 1'b0; i_addr = 28'h0000010; pend_i = 1'b1;
        @(negedge clk);
        chk("mid_busy_read", o_mem_read, 1'b1);
        do_reset();
        @(negedge clk);
        new_req(1'b0);
        new_req(1'b1);
        do_txn(1'b0, won);
        chk("post_rst_tie_d", won, 1'b1);
        clear_reqs();

        // D-first instance
        sel = 1'b1;
        @(negedge clk);
        new_req(1'b0);
        new_req(1'b1);
        for (int k = 0; k < 6; k++) begin
            do_txn(1'b1, won);
            chk("prio_all_d", won, 1'b1);
        end
        d_read = 1'b0; d_write = 1'b0; pend_d = 1'b0;
        do_txn(1'b0, won);
        chk("prio_i_alone", won, 1'b0);
        for (int n = 0; n < 20; n++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) new_req(1'b0);
            if (!pend_d && $urandom_range(0, 1) == 1) new_req(1'b1);
            if (!pend_i && !pend_d) new_req(1'($urandom_range(0, 1)));
            do_txn(1'b0, won);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
